// File: rtl/shift_defs.sv
// Shared definitions for the sequential shift unit: FSM encodings,
// default widths and shift-direction constants.
package shift_defs;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int SHAMT_WIDTH_DEF = 5;

  localparam logic DIR_SLL = 1'b1;
  localparam logic DIR_SRA = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter stage: shifts by a runtime power-of-two amount when
// enabled, otherwise passes the input through. Purely combinational.
module shift_stage
  import shift_defs::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int AMT_WIDTH  = SHAMT_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] in_i,
  input  logic [AMT_WIDTH-1:0]  amount_i,
  input  logic                  dir_i,
  input  logic                  enable_i,
  output logic [DATA_WIDTH-1:0] out_o
);

  // NOTE: out_o gets a default before any branch so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    out_o = in_i;
    if (enable_i) begin
      if (dir_i == DIR_SLL) out_o = in_i << amount_i;
      else                  out_o = DATA_WIDTH'($signed(in_i) >>> amount_i);
    end
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle SLL/SRA unit: one barrel stage (16, 8, 4, 2, 1) per clock,
// start-pulse / one-cycle result-ready handshake.
module shift_unit_seq
  import shift_defs::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  data_operandA,
  input  logic [SHAMT_WIDTH-1:0] ctrl_shamt,
  input  logic                   ctrl_sll,
  input  logic                   ctrl_sra,
  output logic [DATA_WIDTH-1:0]  data_result,
  output logic                   data_resultRDY,
  output logic                   busy
);

  localparam int KW = (SHAMT_WIDTH > 1) ? $clog2(SHAMT_WIDTH) : 1;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  work_q, work_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic [SHAMT_WIDTH-1:0] shamt_q, shamt_d;
  logic [KW-1:0]          k_q, k_d;
  logic                   dir_q, dir_d;
  logic                   busy_q, busy_d;

  logic                   accept;
  logic [SHAMT_WIDTH-1:0] stage_amt;
  logic [DATA_WIDTH-1:0]  stage_out;

  // DONE behaves like IDLE for acceptance so ops can run back-to-back.
  assign accept    = (ctrl_sll | ctrl_sra) && (state_q != S_SHIFT);
  assign stage_amt = SHAMT_WIDTH'(1) << k_q;

  shift_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .AMT_WIDTH  (SHAMT_WIDTH)
  ) u_stage (
    .in_i     (work_q),
    .amount_i (stage_amt),
    .dir_i    (dir_q),
    .enable_i (shamt_q[k_q]),
    .out_o    (stage_out)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: state_d = accept ? S_SHIFT : S_IDLE;
      S_SHIFT:        state_d = (k_q == '0) ? S_DONE : S_SHIFT;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_resultRDY = (state_q == S_DONE);
    data_result    = result_q;
    busy           = busy_q;
  end

  always_comb begin
    work_d   = work_q;
    result_d = result_q;
    shamt_d  = shamt_q;
    k_d      = k_q;
    dir_d    = dir_q;
    busy_d   = (state_d == S_SHIFT);
    if (accept) begin
      work_d  = data_operandA;
      shamt_d = ctrl_shamt;
      dir_d   = ctrl_sll ? DIR_SLL : DIR_SRA;
      k_d     = KW'(SHAMT_WIDTH - 1);
    end else if (state_q == S_SHIFT) begin
      work_d = stage_out;
      if (k_q == '0) result_d = stage_out;
      else           k_d      = k_q - KW'(1);
    end
  end

  // NOTE: every register here is a handful of flops, so all of them take the
  // async reset; an abort mid-operation leaves no stale state behind.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      work_q   <= '0;
      result_q <= '0;
      shamt_q  <= '0;
      k_q      <= '0;
      dir_q    <= DIR_SRA;
      busy_q   <= 1'b0;
    end else begin
      work_q   <= work_d;
      result_q <= result_d;
      shamt_q  <= shamt_d;
      k_q      <= k_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq: directed cases plus randomized
// ops against a plain-arithmetic shift model.
module tb_shift_unit_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [4:0]  ctrl_shamt;
  logic        ctrl_sll;
  logic        ctrl_sra;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] held  = 32'h0;

  shift_unit_seq dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .ctrl_shamt     (ctrl_shamt),
    .ctrl_sll       (ctrl_sll),
    .ctrl_sra       (ctrl_sra),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input bit left, input logic [31:0] a, input int s);
    logic signed [31:0] sa;
    sa = a;
    if (left) return a << s;
    return sa >>> s;
  endfunction

  task automatic scramble();
    data_operandA = $urandom;
    ctrl_shamt    = 5'($urandom);
  endtask

  // Called at a negedge; leaves the bench at the negedge of cycle 6.
  task automatic do_op(input bit sll, input bit sra, input logic [31:0] a,
                       input logic [4:0] s, input int glitch, input string name);
    logic [31:0] exp;
    exp = ref_shift(sll, a, int'(s));
    data_operandA = a;
    ctrl_shamt    = s;
    ctrl_sll      = sll;
    ctrl_sra      = sra;
    @(negedge clock);
    ctrl_sll = 1'b0;
    ctrl_sra = 1'b0;
    scramble();
    for (int c = 1; c <= 5; c++) begin
      if (c == glitch) begin
        ctrl_sll = 1'($urandom_range(0, 1));
        ctrl_sra = ~ctrl_sll;
      end
      check({name, "/busy"}, 32'(busy), 32'd1);
      check({name, "/rdy_early"}, 32'(data_resultRDY), 32'd0);
      check({name, "/held"}, data_result, held);
      @(negedge clock);
      ctrl_sll = 1'b0;
      ctrl_sra = 1'b0;
      scramble();
    end
    check({name, "/busy_done"}, 32'(busy), 32'd0);
    check({name, "/rdy"}, 32'(data_resultRDY), 32'd1);
    check({name, "/result"}, data_result, exp);
    held = exp;
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check({name, "/idle_rdy"}, 32'(data_resultRDY), 32'd0);
      check({name, "/idle_busy"}, 32'(busy), 32'd0);
      check({name, "/idle_held"}, data_result, held);
    end
  endtask

  initial begin
    reset         = 1'b1;
    ctrl_sll      = 1'b0;
    ctrl_sra      = 1'b0;
    data_operandA = 32'h0;
    ctrl_shamt    = 5'd0;
    repeat (2) @(negedge clock);
    check("reset/result", data_result, 32'h0);
    check("reset/rdy", 32'(data_resultRDY), 32'd0);
    check("reset/busy", 32'(busy), 32'd0);
    reset = 1'b0;
    idle(2, "post_reset");

    do_op(1'b1, 1'b0, 32'h0000_0001, 5'd31, 0, "sll31");
    idle(1, "sll31");
    do_op(1'b0, 1'b1, 32'h8000_0000, 5'd4, 0, "sra_neg");
    idle(1, "sra_neg");
    do_op(1'b0, 1'b1, 32'h7FFF_FFF0, 5'd4, 0, "sra_pos");
    idle(1, "sra_pos");
    do_op(1'b1, 1'b0, 32'hDEAD_BEEF, 5'd0, 0, "sll0");
    idle(1, "sll0");
    do_op(1'b1, 1'b0, 32'hDEAD_BEEF, 5'd8, 0, "sll8");
    idle(1, "sll8");
    do_op(1'b0, 1'b1, 32'hFFFF_0000, 5'd16, 3, "ignore_start");
    idle(1, "ignore_start");
    do_op(1'b1, 1'b1, 32'h0000_0001, 5'd1, 0, "both_ctrl");
    idle(1, "both_ctrl");

    // Back-to-back: second start in the DONE cycle of the first.
    do_op(1'b1, 1'b0, 32'h1234_5678, 5'd4, 0, "b2b_first");
    do_op(1'b0, 1'b1, 32'h9000_0001, 5'd3, 0, "b2b_second");
    idle(2, "b2b");

    // Asynchronous reset in cycle 3 of an op.
    data_operandA = 32'hCAFE_F00D;
    ctrl_shamt    = 5'd5;
    ctrl_sll      = 1'b1;
    @(negedge clock);
    ctrl_sll = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    held = 32'h0;
    check("abort/result", data_result, 32'h0);
    check("abort/rdy", 32'(data_resultRDY), 32'd0);
    check("abort/busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    idle(7, "abort_no_rdy");

    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    do_op(1'b0, 1'b1, 32'hF0F0_1234, 5'd12, 0, "restart");
    idle(1, "restart");

    for (int i = 0; i < 40; i++) begin
      int mode;
      bit sll, sra;
      mode = int'($urandom_range(0, 2));
      sll  = (mode != 1);
      sra  = (mode != 0);
      do_op(sll, sra, $urandom, 5'($urandom), int'($urandom_range(0, 5)), "rand");
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)), "rand");
    end
    idle(1, "final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
